sump_sample_tx: RTL and testbench

Transmit-side partner of the analyzer core's sample output. It accepts 32-bit sample words from the core over a strobe/ready handshake and serializes the enabled bytes of each word, LSB byte first, as 8N1 UART frames toward the host. It sits between the core's transmit port and the UART TX pin, and produces the core's transmit-ready input.

---
 rtl/logip_pkg.sv | 24 ++
 rtl/uart_byte_tx.sv | 112 +++++++++++
 rtl/sump_sample_tx.sv | 106 ++++++++++
 tb/tb_sump_sample_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// Shared types and constants for the SUMP sample transmit path.
package logip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int SUMP_WORD_W = 32;
    localparam int SUMP_BYTES  = 4;
    localparam int DATA_BITS   = 8;
    localparam int STOP_BITS   = 1;

    // Index of the lowest set bit of a byte-group mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_idx(input logic [SUMP_BYTES-1:0] m);
        lowest_idx = 2'd0;
        for (int i = SUMP_BYTES - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; a start strobe in the last stop-bit cycle chains the next frame with no gap.
module uart_byte_tx
    import logip_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_last;

    assign baud_last = (baud_q == BAUD_LAST);
    assign done_o    = (state_q == STOP) && baud_last;
    assign busy_o    = (state_q != IDLE);
    assign tx_o      = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    baud_d  = '0;
                    shreg_d = byte_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (start_i) begin
                        state_d = START;
                        shreg_d = byte_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Line register resets high asynchronously so an aborted frame leaves the line idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: rtl/sump_sample_tx.sv
// Word handshake and byte sequencer feeding the 8N1 serializer toward the host.
module sump_sample_tx
    import logip_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int WORD_BYTES  = SUMP_BYTES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_stb_i,
    input  logic [SUMP_WORD_W-1:0] tx_i,
    input  logic [WORD_BYTES-1:0]  grp_en_i,
    output logic                   tx_rdy_o,
    output logic                   uart_tx_o,
    output logic                   busy_o
);

    logic [SUMP_WORD_W-1:0] word_q, word_d;
    logic [WORD_BYTES-1:0]  rem_q, rem_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic                   ser_start;
    logic                   ser_done;
    logic                   ser_busy;
    logic [SUMP_WORD_W-1:0] src_word;
    logic [WORD_BYTES-1:0]  src_mask;
    logic [1:0]             idx;
    logic [7:0]             byte_sel;

    assign accept    = tx_stb_i && rdy_q;
    assign tx_rdy_o  = rdy_q;
    assign busy_o    = busy_q;

    // Fresh word on acceptance, otherwise the latched word and its remaining mask.
    always_comb begin
        src_word = word_q;
        src_mask = rem_q;
        if (accept) begin
            src_word = tx_i;
            src_mask = grp_en_i;
        end
        idx      = lowest_idx(src_mask);
        byte_sel = src_word[{idx, 3'b000} +: 8];
    end

    always_comb begin
        word_d    = word_q;
        rem_d     = rem_q;
        rdy_d     = rdy_q;
        busy_d    = busy_q;
        ser_start = 1'b0;
        if (accept) begin
            word_d = tx_i;
            if (|grp_en_i) begin
                ser_start = 1'b1;
                rdy_d     = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (ser_done) begin
            if (|rem_q) begin
                ser_start = 1'b1;
            end else begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
        end
        if (ser_start) begin
            rem_d = src_mask & ~(WORD_BYTES'(1) << idx);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        word_q <= word_d;
    end

    uart_byte_tx #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_ser (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(ser_start),
        .byte_i (byte_sel),
        .done_o (ser_done),
        .busy_o (ser_busy),
        .tx_o   (uart_tx_o)
    );

    // Serializer activity is fully mirrored by busy_q; kept for observability.
    logic unused_ok;
    assign unused_ok = ser_busy;

endmodule

// File: tb/tb_sump_sample_tx.sv
// Directed bench for sump_sample_tx with CLK_PER_BIT=4 and an independent UART line decoder.
module tb_sump_sample_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_stb = 1'b0;
    logic [31:0] tx_word = '0;
    logic [3:0]  grp_en = '0;
    logic        tx_rdy;
    logic        uart_tx;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sump_sample_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tx_stb_i (tx_stb),
        .tx_i     (tx_word),
        .grp_en_i (grp_en),
        .tx_rdy_o (tx_rdy),
        .uart_tx_o(uart_tx),
        .busy_o   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: frame starts on a low line while idle, samples mid-bit.
    int          cyc = 0;
    logic        rx_act = 1'b0;
    int          rx_cnt = 0;
    logic [7:0]  rx_b = '0;
    logic [7:0]  rx_q[$];
    int          st_q[$];
    int          stop_err = 0;
    int          low_cnt = 0;
    int          busy_cnt = 0;
    int          line_low = 0;

    always @(negedge clk) begin
        cyc++;
        if (!tx_rdy) low_cnt++;
        if (busy) busy_cnt++;
        if (!uart_tx) line_low++;
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (!uart_tx) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                st_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && ((rx_cnt - CPB/2) % CPB) == 0)
                rx_b[(rx_cnt - CPB - CPB/2) / CPB] = uart_tx;
            if (rx_cnt == 9*CPB + CPB/2) begin
                if (!uart_tx) stop_err++;
                rx_q.push_back(rx_b);
            end
            if (rx_cnt == 10*CPB - 1) rx_act = 1'b0;
        end
    end

    task automatic clr();
        rx_q.delete();
        st_q.delete();
        stop_err = 0;
        low_cnt  = 0;
        busy_cnt = 0;
        line_low = 0;
    endtask

    task automatic send(input logic [31:0] w, input logic [3:0] m);
        tx_word = w;
        grp_en  = m;
        tx_stb  = 1'b1;
        @(posedge clk);
        #1 tx_stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(tx_rdy && !rx_act) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= budget) chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] e[]);
        chk({tag, "_nbytes"}, rx_q.size(), e.size());
        for (int i = 0; i < e.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, e[i]});
        for (int i = 1; i < st_q.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), st_q[i] - st_q[i-1], 10*CPB);
        chk({tag, "_stop"}, stop_err, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {31'd0, tx_rdy}, 1);
        chk("rst_uart", {31'd0, uart_tx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full word
        clr();
        send(32'h44332211, 4'b1111);
        chk("full_lat_uart", {31'd0, uart_tx}, 0);
        chk("full_lat_rdy", {31'd0, tx_rdy}, 0);
        chk("full_lat_busy", {31'd0, busy}, 1);
        wait_idle(400);
        chk_bytes("full", '{8'h11, 8'h22, 8'h33, 8'h44});
        chk("full_rdy_low", low_cnt, 160);
        chk("full_busy", busy_cnt, 160);

        // Partial mask
        clr();
        send(32'hDDCCBBAA, 4'b0101);
        wait_idle(300);
        chk_bytes("part", '{8'hAA, 8'hCC});
        chk("part_rdy_low", low_cnt, 80);

        // Zero mask
        clr();
        send(32'h12345678, 4'b0000);
        repeat (20) @(posedge clk);
        #1;
        chk("zero_rdy_low", low_cnt, 0);
        chk("zero_busy", busy_cnt, 0);
        chk("zero_line", line_low, 0);

        // Strobe while busy is ignored
        clr();
        send(32'h44332211, 4'b0011);
        repeat (15) @(posedge clk);
        #1 send(32'hFFFFFFFF, 4'b1111);
        wait_idle(300);
        chk_bytes("bsy", '{8'h11, 8'h22});
        chk("bsy_rdy_low", low_cnt, 80);

        // Back-to-back with strobe held high
        clr();
        tx_word = 32'h000000A5;
        grp_en  = 4'b0001;
        tx_stb  = 1'b1;
        @(posedge clk);
        #1 tx_word = 32'h0000005A;
        begin
            int n = 0;
            while (!tx_rdy && n < 100) begin
                @(posedge clk);
                #1 n++;
            end
            if (n >= 100) chk("b2b_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1 tx_stb = 1'b0;
        wait_idle(200);
        chk("b2b_nbytes", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("b2b_b0", {24'd0, rx_q[0]}, 32'hA5);
            chk("b2b_b1", {24'd0, rx_q[1]}, 32'h5A);
            chk("b2b_gap", st_q[1] - st_q[0], 10*CPB + 1);
        end
        chk("b2b_rdy_low", low_cnt, 80);

        // Reset in the middle of data bit 3
        clr();
        send(32'h00000011, 4'b0001);
        repeat (17) @(posedge clk);
        #1;
        chk("mid_bit3", {31'd0, uart_tx}, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_uart", {31'd0, uart_tx}, 1);
        chk("mid_rst_rdy", {31'd0, tx_rdy}, 1);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr();
        send(32'h000000C3, 4'b0001);
        wait_idle(200);
        chk_bytes("post", '{8'hC3});
        chk("post_rdy_low", low_cnt, 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
